// File: rtl/mprj_io_cfg_seq.sv
// mprj_io_cfg_seq: per-pad GPIO config register file with a serial shift/load sequencer for two pad chains
module mprj_io_cfg_seq #(
    parameter int TOTAL_PADS = 38,
    parameter int AREA1PADS = 19,
    parameter int CFG_BITS = 13,
    parameter int ADDR_W = 6,
    parameter int CLK_DIV = 1,
    parameter logic [CFG_BITS-1:0] CFG_INIT = 13'h0403,
    parameter bit AUTO_LOAD = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    output logic [CFG_BITS-1:0] cfg_rdata,
    input  logic                load_req,
    output logic                busy,
    output logic                done,
    output logic                wr_err,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_data_out_1,
    output logic                serial_data_out_2
);
    localparam int A2 = TOTAL_PADS - AREA1PADS;
    localparam int MAXP = AREA1PADS > A2 ? AREA1PADS : A2;
    localparam int N = MAXP * CFG_BITS;
    localparam int Z1 = MAXP - AREA1PADS;
    localparam int Z2 = MAXP - A2;
    localparam int BW = $clog2(N + 1);
    localparam int PHW = $clog2(CLK_DIV + 1);
    localparam int PW = TOTAL_PADS > 1 ? $clog2(TOTAL_PADS) : 1;
    localparam int WW = MAXP > 1 ? $clog2(MAXP) : 1;
    localparam int KW = CFG_BITS > 1 ? $clog2(CFG_BITS) : 1;
    localparam logic [ADDR_W:0] NP = (ADDR_W + 1)'(TOTAL_PADS);

    typedef enum logic [2:0] {IDLE, SHIFT, LATCH, LOAD, FIN} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [PHW-1:0]      ph_q, ph_d;
    logic                hi_q, hi_d;
    logic                wr_err_q, wr_err_d;
    logic                auto_q;
    logic [CFG_BITS-1:0] cfg_q [TOTAL_PADS];
    logic [CFG_BITS-1:0] cfg_d [TOTAL_PADS];

    logic          addr_ok, ph_last;
    logic [WW-1:0] w;
    logic [KW-1:0] k;
    logic [PW-1:0] p1, p2;

    assign addr_ok = {1'b0, cfg_addr} < NP;
    assign ph_last = ph_q == PHW'(CLK_DIV - 1);
    // Shift position -> (word slot along the longest chain, bit within word, MSB first)
    assign w = WW'(bit_q / BW'(CFG_BITS));
    assign k = KW'(CFG_BITS - 1) - KW'(bit_q % BW'(CFG_BITS));
    assign p1 = PW'(MAXP - 1) - PW'(w);
    assign p2 = PW'(AREA1PADS - Z2) + PW'(w);

    assign cfg_rdata = addr_ok ? cfg_q[cfg_addr[PW-1:0]] : '0;
    assign busy = state_q inside {SHIFT, LATCH, LOAD};
    assign done = state_q == FIN;
    assign wr_err = wr_err_q;
    assign serial_clock = state_q == SHIFT && hi_q;
    assign serial_load = state_q == LOAD;
    assign serial_data_out_1 = state_q == SHIFT && int'(w) >= Z1 && cfg_q[p1][k];
    assign serial_data_out_2 = state_q == SHIFT && int'(w) >= Z2 && cfg_q[p2][k];

    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        ph_d = ph_q;
        hi_d = hi_q;
        cfg_d = cfg_q;
        wr_err_d = cfg_we && !(state_q == IDLE && addr_ok);
        if (cfg_we && state_q == IDLE && addr_ok) cfg_d[cfg_addr[PW-1:0]] = cfg_wdata;
        if (busy) ph_d = ph_last ? '0 : ph_q + PHW'(1);
        case (state_q)
            IDLE: if (load_req || auto_q) begin
                state_d = SHIFT;
                bit_d = '0;
                hi_d = 1'b0;
            end
            SHIFT: if (ph_last) begin
                hi_d = !hi_q;
                if (hi_q) begin
                    bit_d = bit_q + BW'(1);
                    state_d = bit_q == BW'(N - 1) ? LATCH : SHIFT;
                end
            end
            LATCH: state_d = ph_last ? LOAD : LATCH;
            LOAD: state_d = ph_last ? FIN : LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q <= '0;
            ph_q <= '0;
            hi_q <= 1'b0;
            wr_err_q <= 1'b0;
            auto_q <= AUTO_LOAD;
            cfg_q <= '{default: CFG_INIT};
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            ph_q <= ph_d;
            hi_q <= hi_d;
            wr_err_q <= wr_err_d;
            auto_q <= 1'b0;
            cfg_q <= cfg_d;
        end
    end
endmodule
